// File: rtl/lockstep_pkg.sv
// Shared definitions for the lockstep comparator: FSM encoding and default parameters.
package lockstep_pkg;

   localparam int unsigned DEF_WIDTH = 8;
   localparam int unsigned DEF_NLANE = 2;
   localparam int unsigned DEF_DEPTH = 4;
   localparam int unsigned DEF_CNT_W = 16;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      FAIL = 2'd2
   } state_e;

endpackage

// File: rtl/lockstep_skew_fifo.sv
// Skew buffer holding reference samples until the checked side catches up.
module lockstep_skew_fifo #(
   parameter int unsigned DATA_W = 16,
   parameter int unsigned DEPTH  = 4
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     push,
   input  logic                     pop,
   input  logic [DATA_W-1:0]        wdata,
   output logic [DATA_W-1:0]        rdata,
   output logic                     full,
   output logic                     empty,
   output logic [$clog2(DEPTH):0]   count
);

   localparam int unsigned AW = $clog2(DEPTH);
   localparam int unsigned CW = AW + 1;

   logic [DATA_W-1:0] mem_q [DEPTH];
   logic [AW-1:0]     wptr_q;
   logic [AW-1:0]     rptr_q;
   logic [CW-1:0]     count_q;

   // Storage carries no reset; occupancy alone defines validity.
   always_ff @(posedge clk) begin
      if (push) mem_q[wptr_q] <= wdata;
   end

   // Pointers wrap naturally since DEPTH is a power of two.
   always_ff @(posedge clk) begin
      if (!reset) begin
         wptr_q  <= '0;
         rptr_q  <= '0;
         count_q <= '0;
      end else begin
         if (push) wptr_q <= wptr_q + AW'(1);
         if (pop)  rptr_q <= rptr_q + AW'(1);
         unique case ({push, pop})
            2'b10:   count_q <= count_q + CW'(1);
            2'b01:   count_q <= count_q - CW'(1);
            default: count_q <= count_q;
         endcase
      end
   end

   assign rdata = mem_q[rptr_q];
   assign full  = (count_q == CW'(DEPTH));
   assign empty = (count_q == '0);
   assign count = count_q;

endmodule

// File: rtl/lockstep_compare.sv
// Lane-wise lockstep comparator with skew buffer, sticky error and saturating mismatch count.
// Define LOCKSTEP_FIRST_FAIL_CAPTURE_EN to add first-mismatch capture outputs (cap_a/cap_b/cap_lane).
module lockstep_compare
   import lockstep_pkg::*;
#(
   parameter int unsigned WIDTH = DEF_WIDTH,
   parameter int unsigned NLANE = DEF_NLANE,
   parameter int unsigned DEPTH = DEF_DEPTH,
   parameter int unsigned CNT_W = DEF_CNT_W
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     clk_enable,
   input  logic                     arm,
   input  logic                     clr_err,
   input  logic                     a_valid,
   input  logic [NLANE*WIDTH-1:0]   a_data,
   input  logic                     b_valid,
   input  logic [NLANE*WIDTH-1:0]   b_data,
   output logic                     ce_out,
   output logic                     cmp_valid,
   output logic                     match,
   output logic [NLANE-1:0]         lane_mis,
   output logic                     err_sticky,
   output logic [CNT_W-1:0]         mis_cnt,
   output logic                     overflow,
   output logic                     underflow,
   output logic [1:0]               state
`ifdef LOCKSTEP_FIRST_FAIL_CAPTURE_EN
   ,
   output logic [NLANE*WIDTH-1:0]   cap_a,
   output logic [NLANE*WIDTH-1:0]   cap_b,
   output logic [NLANE-1:0]         cap_lane
`endif
);

   localparam int unsigned DW = NLANE * WIDTH;
   localparam int unsigned CW = $clog2(DEPTH) + 1;

   state_e            state_q, state_d;
   logic              cmp_valid_q, cmp_valid_d;
   logic              match_q, match_d;
   logic [NLANE-1:0]  lane_mis_q, lane_mis_d;
   logic              err_q, err_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic              ovf_q, ovf_d;
   logic              unf_q, unf_d;

   logic              fifo_full, fifo_empty;
   logic [CW-1:0]     fifo_count;
   logic [DW-1:0]     fifo_rdata;
   logic              active, push, pop, bypass, do_cmp, ovf, unf, mis_hit, err_evt, clr;
   logic [DW-1:0]     ref_data;
   logic [NLANE-1:0]  lane_vec;
   logic              unused_count;

   assign unused_count = ^fifo_count;

   // Datapath decode: a simultaneous push/pop on an empty buffer bypasses storage.
   always_comb begin
      active   = clk_enable && (state_q != IDLE);
      bypass   = active && a_valid && b_valid && fifo_empty;
      pop      = active && b_valid && !fifo_empty;
      push     = active && a_valid && (b_valid ? !fifo_empty : !fifo_full);
      ovf      = active && a_valid && !b_valid && fifo_full;
      unf      = active && b_valid && !a_valid && fifo_empty;
      do_cmp   = pop || bypass;
      ref_data = bypass ? a_data : fifo_rdata;
      lane_vec = '0;
      for (int unsigned l = 0; l < NLANE; l++) begin
         lane_vec[l] = (ref_data[l*WIDTH +: WIDTH] != b_data[l*WIDTH +: WIDTH]);
      end
      mis_hit  = do_cmp && (|lane_vec);
      err_evt  = mis_hit || ovf || unf;
      clr      = active && clr_err;
   end

   lockstep_skew_fifo #(
      .DATA_W (DW),
      .DEPTH  (DEPTH)
   ) u_fifo (
      .clk   (clk),
      .reset (reset),
      .push  (push),
      .pop   (pop),
      .wdata (a_data),
      .rdata (fifo_rdata),
      .full  (fifo_full),
      .empty (fifo_empty),
      .count (fifo_count)
   );

   // Next-state and registered-output logic; everything holds while clk_enable is low.
   always_comb begin
      state_d     = state_q;
      cmp_valid_d = cmp_valid_q;
      match_d     = match_q;
      lane_mis_d  = lane_mis_q;
      err_d       = err_q;
      cnt_d       = cnt_q;
      ovf_d       = ovf_q;
      unf_d       = unf_q;
      if (clk_enable) begin
         cmp_valid_d = do_cmp;
         match_d     = do_cmp && !(|lane_vec);
         lane_mis_d  = do_cmp ? lane_vec : '0;
         ovf_d       = ovf;
         unf_d       = unf;
         // A new error in the same cycle as clr_err takes priority.
         if (clr) begin
            err_d = 1'b0;
            cnt_d = '0;
         end
         if (err_evt) err_d = 1'b1;
         if (mis_hit && (cnt_d != '1)) cnt_d = cnt_d + CNT_W'(1);
         unique case (state_q)
            IDLE:    if (arm) state_d = RUN;
            RUN:     if (err_evt) state_d = FAIL;
            FAIL:    if (clr_err && !err_evt) state_d = RUN;
            default: state_d = IDLE;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         state_q     <= IDLE;
         cmp_valid_q <= 1'b0;
         match_q     <= 1'b0;
         lane_mis_q  <= '0;
         err_q       <= 1'b0;
         cnt_q       <= '0;
         ovf_q       <= 1'b0;
         unf_q       <= 1'b0;
      end else begin
         state_q     <= state_d;
         cmp_valid_q <= cmp_valid_d;
         match_q     <= match_d;
         lane_mis_q  <= lane_mis_d;
         err_q       <= err_d;
         cnt_q       <= cnt_d;
         ovf_q       <= ovf_d;
         unf_q       <= unf_d;
      end
   end

   assign ce_out     = clk_enable;
   assign cmp_valid  = cmp_valid_q;
   assign match      = match_q;
   assign lane_mis   = lane_mis_q;
   assign err_sticky = err_q;
   assign mis_cnt    = cnt_q;
   assign overflow   = ovf_q;
   assign underflow  = unf_q;
   assign state      = state_q;

`ifdef LOCKSTEP_FIRST_FAIL_CAPTURE_EN
   logic [DW-1:0]    cap_a_q, cap_a_d, cap_b_q, cap_b_d;
   logic [NLANE-1:0] cap_lane_q, cap_lane_d;
   logic             cap_done_q, cap_done_d;

   // Freeze operands of the first mismatch seen since reset or clr_err.
   always_comb begin
      cap_a_d    = cap_a_q;
      cap_b_d    = cap_b_q;
      cap_lane_d = cap_lane_q;
      cap_done_d = cap_done_q;
      if (clr) begin
         cap_a_d    = '0;
         cap_b_d    = '0;
         cap_lane_d = '0;
         cap_done_d = 1'b0;
      end
      if (mis_hit && (!cap_done_q || clr)) begin
         cap_a_d    = ref_data;
         cap_b_d    = b_data;
         cap_lane_d = lane_vec;
         cap_done_d = 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         cap_a_q    <= '0;
         cap_b_q    <= '0;
         cap_lane_q <= '0;
         cap_done_q <= 1'b0;
      end else begin
         cap_a_q    <= cap_a_d;
         cap_b_q    <= cap_b_d;
         cap_lane_q <= cap_lane_d;
         cap_done_q <= cap_done_d;
      end
   end

   assign cap_a    = cap_a_q;
   assign cap_b    = cap_b_q;
   assign cap_lane = cap_lane_q;
`endif

endmodule

// File: doc/lockstep_compare.md
LOCKSTEP_COMPARE -- requirements
Module: lockstep_compare

Interface
REQ-001 Parameter WIDTH, default 8: bits per lane.
REQ-002 Parameter NLANE, default 2: independent compare lanes.
REQ-003 Parameter DEPTH, default 4: skew-buffer entries, power of two, at least 2.
REQ-004 Parameter CNT_W, default 16: mismatch counter width.
REQ-005 Ports SHALL be as follows. One clock; reset is synchronous and active-low.
- clk  in  1  clock; all state changes on its rising edge.
- reset  in  1  synchronous, active-low reset.
- clk_enable  in  1  when low, no state changes except reset.
- arm  in  1  pulse; IDLE->RUN.
- clr_err  in  1  pulse; clears the sticky error and the counter.
- a_valid  in  1  reference-side sample valid.
- a_data  in  NLANE*WIDTH  reference-side sample.
- b_valid  in  1  checked-side sample valid.
- b_data  in  NLANE*WIDTH  checked-side sample.
- ce_out  out  1  equals clk_enable (combinational).
- cmp_valid  out  1  registered; one compare completed.
- match  out  1  registered; every lane equal on this compare.
- lane_mis  out  NLANE  registered; bit set per unequal lane.
- err_sticky  out  1  set on any mismatch, overflow or underflow.
- mis_cnt  out  CNT_W  saturating mismatch count.
- overflow  out  1  one-cycle pulse; A sample dropped, buffer full.
- underflow  out  1  one-cycle pulse; B sample with no A available.
- state  out  2  IDLE=0, RUN=1, FAIL=2.

Function
REQ-006 All actions below SHALL occur only on cycles where clk_enable=1.
REQ-007 In IDLE, a_valid and b_valid SHALL be ignored; arm moves to RUN.
REQ-008 In RUN or FAIL, a_valid SHALL push a_data into the skew buffer; b_valid SHALL pop the oldest entry and compare it lane-wise with b_data.
REQ-009 If a_valid and b_valid occur together with the buffer empty, a_data SHALL bypass the buffer and be compared directly; nothing is stored.
REQ-010 If a_valid and b_valid occur together with the buffer non-empty, the push and pop SHALL both happen; the occupancy is unchanged.
REQ-011 The compare result (cmp_valid, match, lane_mis) SHALL be registered, with a latency of 1 cycle after b_valid.
REQ-012 cmp_valid SHALL be low on non-compare cycles; lane_mis SHALL be zero when cmp_valid is low.
REQ-013 If a_valid arrives with the buffer full and no simultaneous pop, the sample SHALL be dropped and overflow pulsed.
REQ-014 If b_valid arrives with the buffer empty and no a_valid, underflow SHALL pulse and no compare occurs (cmp_valid=0).
REQ-015 Each compare with any lane unequal SHALL increment mis_cnt by 1; mis_cnt saturates at 2^CNT_W-1 and does not wrap.
REQ-016 Any mismatch, overflow or underflow in RUN SHALL set err_sticky and move the FSM to FAIL on the same edge that the registered result appears.
REQ-017 In FAIL, comparison and counting SHALL continue.
REQ-018 clr_err SHALL clear err_sticky and mis_cnt, and move FAIL->RUN.
REQ-019 If clr_err and a new error occur in the same cycle, the error SHALL win: err_sticky=1, mis_cnt=1, state FAIL.
REQ-020 arm in RUN or FAIL SHALL have no effect; clr_err in IDLE SHALL have no effect.
REQ-021 Buffer pointers SHALL wrap modulo DEPTH; occupancy is tracked with log2(DEPTH)+1 bits.

Reset
REQ-022 On reset=0 at a clock edge, regardless of clk_enable: state=IDLE, buffer empty, and every registered output zero.
REQ-023 Reset asserted mid-stream SHALL discard buffered samples; no compare output is produced for them.

Configuration
REQ-024 With LOCKSTEP_FIRST_FAIL_CAPTURE_EN defined, the block SHALL add outputs cap_a and cap_b (each NLANE*WIDTH) and cap_lane (NLANE).
REQ-025 These capture the operands and lane mask of the first mismatch after reset or clr_err, and hold them until the next reset or clr_err.
REQ-026 Without the macro, these outputs and their registers SHALL be absent.

Structure
REQ-027 Package lockstep_pkg SHALL hold the state encoding constants (IDLE, RUN, FAIL) and the default parameter values.
REQ-028 The skew buffer SHALL be the sub-module lockstep_skew_fifo, parameterised by DATA_W=NLANE*WIDTH and DEPTH, providing full, empty and count.

Verification
REQ-029 The bench SHALL cover these directed scenarios (WIDTH=8, NLANE=2, DEPTH=4):
- Reset, arm, then a_valid with a_data=0x1234 and two cycles later b_valid with b_data=0x1234 -> next cycle cmp_valid=1, match=1, lane_mis=00, state RUN.
- a_data=0x1234, b_data=0x12FF -> lane_mis=01, mis_cnt=1, err_sticky=1, state FAIL; then clr_err -> mis_cnt=0, state RUN.
- Five a_valid pushes with no b_valid -> overflow pulses on the 5th push only; four subsequent b_valid pops compare the first four samples in order.
- b_valid with the buffer empty and a_valid=0 -> underflow=1, cmp_valid=0, state FAIL.
- CNT_W=2 and five mismatches -> mis_cnt holds at 3.
- Three samples buffered, then reset=0 for one cycle -> state IDLE, all outputs zero; after arm, b_valid gives underflow.
